// File: rtl/token_pass_sequencer.sv
// Pass-level sequencer: walks a pass through tile_num tiles, each stepping through
// weight load, FIFO/PE init, preheat, normal loop and drain, with a per-phase watchdog and abort.
`timescale 1ns/1ps

module token_pass_sequencer #(
  parameter int TILE_W = 16,
  parameter int TO_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pass_start_i,
  input  logic              abort_i,
  input  logic [1:0]        layer_type_i,
  input  logic [TILE_W-1:0] tile_num_i,
  input  logic              weight_reuse_i,
  input  logic              bias_en_i,
  input  logic [TO_W-1:0]   timeout_cycles_i,
  input  logic              weight_load_done_i,
  input  logic              preheat_done_i,
  input  logic              normal_loop_done_i,
  input  logic              drain_done_i,
  output logic              weight_load_state_o,
  output logic              init_fifo_pe_state_o,
  output logic              preheat_state_o,
  output logic              normal_loop_state_o,
  output logic              drain_state_o,
  output logic              phase_start_o,
  output logic [1:0]        layer_type_o,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              is_bias_o,
  output logic              busy_o,
  output logic              pass_done_o,
  output logic              error_o,
  output logic [3:0]        err_code_o,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WLOAD   = 4'd1,
    S_INIT    = 4'd2,
    S_PREHEAT = 4'd3,
    S_NORMAL  = 4'd4,
    S_DRAIN   = 4'd5,
    S_NEXT    = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [TILE_W-1:0] tile_idx_r;
  logic [TILE_W-1:0] tile_idx_nx_s;
  logic [TILE_W-1:0] tile_num_r;
  logic              reuse_r;
  logic              bias_r;
  logic              bias_nx_s;
  logic [TO_W-1:0]   to_r;
  logic [TO_W-1:0]   wd_cnt_r;
  logic              start_s;
  logic              wd_hit_s;
  logic              last_tile_s;

  function automatic logic is_phase(input state_t s);
    logic r;
    case (s)
      S_WLOAD, S_INIT, S_PREHEAT, S_NORMAL, S_DRAIN: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  assign start_s     = (state_r == S_IDLE) && pass_start_i;
  // wd_cnt_r holds the 1-based cycle number within the current state
  assign wd_hit_s    = (to_r != {TO_W{1'b0}}) && (wd_cnt_r >= to_r);
  assign last_tile_s = ({1'b0, tile_idx_r} + {{TILE_W{1'b0}}, 1'b1}) >= {1'b0, tile_num_r};
  assign bias_nx_s   = start_s ? bias_en_i : bias_r;
  assign tile_idx_o  = tile_idx_r;
  assign state_o     = state_r;

  // Next-state and next-tile-index decode; abort overrides everything outside IDLE
  always_comb begin
    state_nx_s    = state_r;
    tile_idx_nx_s = tile_idx_r;
    if (abort_i && (state_r != S_IDLE)) begin
      state_nx_s    = S_IDLE;
      tile_idx_nx_s = {TILE_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pass_start_i) begin
            tile_idx_nx_s = {TILE_W{1'b0}};
            if (tile_num_i == {TILE_W{1'b0}}) begin
              state_nx_s = S_DONE;
            end else begin
              state_nx_s = S_WLOAD;
            end
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_WLOAD: begin
          if (weight_load_done_i) begin
            state_nx_s = S_INIT;
          end else if (wd_hit_s) begin
            state_nx_s = S_ERR;
          end else begin
            state_nx_s = S_WLOAD;
          end
        end
        S_INIT: begin
          state_nx_s = S_PREHEAT;
        end
        S_PREHEAT: begin
          if (preheat_done_i) begin
            state_nx_s = S_NORMAL;
          end else if (wd_hit_s) begin
            state_nx_s = S_ERR;
          end else begin
            state_nx_s = S_PREHEAT;
          end
        end
        S_NORMAL: begin
          if (normal_loop_done_i) begin
            state_nx_s = S_DRAIN;
          end else if (wd_hit_s) begin
            state_nx_s = S_ERR;
          end else begin
            state_nx_s = S_NORMAL;
          end
        end
        S_DRAIN: begin
          if (drain_done_i) begin
            state_nx_s = S_NEXT;
          end else if (wd_hit_s) begin
            state_nx_s = S_ERR;
          end else begin
            state_nx_s = S_DRAIN;
          end
        end
        S_NEXT: begin
          if (last_tile_s) begin
            state_nx_s = S_DONE;
          end else begin
            tile_idx_nx_s = tile_idx_r + {{(TILE_W-1){1'b0}}, 1'b1};
            if (reuse_r) begin
              state_nx_s = S_INIT;
            end else begin
              state_nx_s = S_WLOAD;
            end
          end
        end
        S_DONE: begin
          state_nx_s    = S_IDLE;
          tile_idx_nx_s = {TILE_W{1'b0}};
        end
        S_ERR: begin
          state_nx_s = S_ERR;
        end
        default: begin
          state_nx_s    = S_IDLE;
          tile_idx_nx_s = {TILE_W{1'b0}};
        end
      endcase
    end
  end

  // State, latched config, watchdog counter and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r              <= S_IDLE;
      tile_idx_r           <= {TILE_W{1'b0}};
      tile_num_r           <= {TILE_W{1'b0}};
      reuse_r              <= 1'b0;
      bias_r               <= 1'b0;
      to_r                 <= {TO_W{1'b0}};
      wd_cnt_r             <= {TO_W{1'b0}};
      layer_type_o         <= 2'd0;
      weight_load_state_o  <= 1'b0;
      init_fifo_pe_state_o <= 1'b0;
      preheat_state_o      <= 1'b0;
      normal_loop_state_o  <= 1'b0;
      drain_state_o        <= 1'b0;
      phase_start_o        <= 1'b0;
      is_bias_o            <= 1'b0;
      busy_o               <= 1'b0;
      pass_done_o          <= 1'b0;
      error_o              <= 1'b0;
      err_code_o           <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      tile_idx_r <= tile_idx_nx_s;

      if (start_s) begin
        tile_num_r   <= tile_num_i;
        reuse_r      <= weight_reuse_i;
        bias_r       <= bias_en_i;
        to_r         <= timeout_cycles_i;
        layer_type_o <= layer_type_i;
      end else begin
        tile_num_r   <= tile_num_r;
        reuse_r      <= reuse_r;
        bias_r       <= bias_r;
        to_r         <= to_r;
        layer_type_o <= layer_type_o;
      end

      // Entry into any state restarts the count at cycle 1; saturate rather than wrap
      if (state_nx_s != state_r) begin
        wd_cnt_r <= {{(TO_W-1){1'b0}}, 1'b1};
      end else if (wd_cnt_r != {TO_W{1'b1}}) begin
        wd_cnt_r <= wd_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end

      weight_load_state_o  <= (state_nx_s == S_WLOAD);
      init_fifo_pe_state_o <= (state_nx_s == S_INIT);
      preheat_state_o      <= (state_nx_s == S_PREHEAT);
      normal_loop_state_o  <= (state_nx_s == S_NORMAL);
      drain_state_o        <= (state_nx_s == S_DRAIN);
      phase_start_o        <= is_phase(state_nx_s) && (state_nx_s != state_r);
      busy_o               <= (state_nx_s != S_IDLE);
      pass_done_o          <= (state_nx_s == S_DONE);
      is_bias_o            <= bias_nx_s && (tile_idx_nx_s == {TILE_W{1'b0}}) &&
                              (state_nx_s != S_IDLE);
      error_o              <= (state_nx_s == S_ERR);

      if (state_nx_s == S_ERR) begin
        if (state_r != S_ERR) begin
          err_code_o <= state_r;
        end else begin
          err_code_o <= err_code_o;
        end
      end else begin
        err_code_o <= 4'd0;
      end
    end
  end

  token_pass_sequencer_chk u_chk (
    .clk                  (clk),
    .rst                  (rst),
    .weight_load_state_o  (weight_load_state_o),
    .init_fifo_pe_state_o (init_fifo_pe_state_o),
    .preheat_state_o      (preheat_state_o),
    .normal_loop_state_o  (normal_loop_state_o),
    .drain_state_o        (drain_state_o),
    .busy_o               (busy_o),
    .pass_done_o          (pass_done_o),
    .error_o              (error_o),
    .state_o              (state_o)
  );

endmodule

// Invariants on the sequencer outputs: phase one-hot, busy/error consistent with state.
module token_pass_sequencer_chk (
  input logic       clk,
  input logic       rst,
  input logic       weight_load_state_o,
  input logic       init_fifo_pe_state_o,
  input logic       preheat_state_o,
  input logic       normal_loop_state_o,
  input logic       drain_state_o,
  input logic       busy_o,
  input logic       pass_done_o,
  input logic       error_o,
  input logic [3:0] state_o
);

  a_phase_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({weight_load_state_o, init_fifo_pe_state_o, preheat_state_o,
              normal_loop_state_o, drain_state_o}));

  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy_o == (state_o != 4'd0));

  a_error_state: assert property (@(posedge clk) disable iff (rst)
    error_o == (state_o == 4'd8));

  a_done_no_err: assert property (@(posedge clk) disable iff (rst)
    !(pass_done_o && error_o));

endmodule

// File: tb/tb_token_pass_sequencer.sv
// Self-checking bench for token_pass_sequencer: vector table, directed corner sequences,
// and randomized stimulus against a pass-script reference model.
`timescale 1ns/1ps

module tb_token_pass_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pass_start = 1'b0, abort = 1'b0;
  logic [1:0]  layer_type = 2'd0;
  logic [15:0] tile_num = 16'd0;
  logic        weight_reuse = 1'b0, bias_en = 1'b0;
  logic [19:0] timeout_cycles = 20'd0;
  logic        wl_done = 1'b0, ph_done = 1'b0, nl_done = 1'b0, dr_done = 1'b0;
  logic        weight_load_state_o, init_fifo_pe_state_o, preheat_state_o;
  logic        normal_loop_state_o, drain_state_o, phase_start_o;
  logic [1:0]  layer_type_o;
  logic [15:0] tile_idx_o;
  logic        is_bias_o, busy_o, pass_done_o, error_o;
  logic [3:0]  err_code_o, state_o;

  int checks = 0;
  int failures = 0;

  token_pass_sequencer #(.TILE_W(16), .TO_W(20)) dut (
    .clk(clk), .rst(rst), .pass_start_i(pass_start), .abort_i(abort),
    .layer_type_i(layer_type), .tile_num_i(tile_num), .weight_reuse_i(weight_reuse),
    .bias_en_i(bias_en), .timeout_cycles_i(timeout_cycles),
    .weight_load_done_i(wl_done), .preheat_done_i(ph_done),
    .normal_loop_done_i(nl_done), .drain_done_i(dr_done),
    .weight_load_state_o(weight_load_state_o), .init_fifo_pe_state_o(init_fifo_pe_state_o),
    .preheat_state_o(preheat_state_o), .normal_loop_state_o(normal_loop_state_o),
    .drain_state_o(drain_state_o), .phase_start_o(phase_start_o),
    .layer_type_o(layer_type_o), .tile_idx_o(tile_idx_o), .is_bias_o(is_bias_o),
    .busy_o(busy_o), .pass_done_o(pass_done_o), .error_o(error_o),
    .err_code_o(err_code_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pass is a script of (phase, tile) steps built at start and consumed
  typedef struct { logic [3:0] code; int tile; } step_t;
  step_t      mq[$];
  bit         m_err;
  logic [3:0] m_ecode, m_prev;
  int         m_etile, m_el, m_to;
  bit         m_bias;
  logic [1:0] m_layer;

  function automatic logic [3:0] m_code();
    if (m_err) return 4'd8;
    if (mq.size() == 0) return 4'd0;
    return mq[0].code;
  endfunction

  function automatic int m_tile();
    if (mq.size() != 0) return mq[0].tile;
    if (m_err) return m_etile;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete(); m_err = 0; m_ecode = 4'd0; m_prev = 4'd0; m_etile = 0;
    m_el = 0; m_to = 0; m_bias = 0; m_layer = 2'd0;
  endtask

  task automatic model_build();
    step_t s;
    m_layer = layer_type; m_bias = bias_en; m_to = int'(timeout_cycles); m_el = 1;
    for (int t = 0; t < int'(tile_num); t++) begin
      if (t == 0 || !weight_reuse) begin s.code = 4'd1; s.tile = t; mq.push_back(s); end
      for (int p = 2; p <= 6; p++) begin s.code = 4'(p); s.tile = t; mq.push_back(s); end
    end
    s.code = 4'd7; s.tile = (tile_num == 16'd0) ? 0 : int'(tile_num) - 1;
    mq.push_back(s);
  endtask

  task automatic model_step();
    logic adv;
    m_prev = m_code();
    if (m_err) begin
      if (abort) m_err = 0;
    end else if (mq.size() == 0) begin
      if (pass_start) model_build();
    end else if (abort) begin
      mq.delete();
    end else begin
      case (mq[0].code)
        4'd1:    adv = wl_done;
        4'd3:    adv = ph_done;
        4'd4:    adv = nl_done;
        4'd5:    adv = dr_done;
        default: adv = 1'b1;
      endcase
      if (adv) begin
        void'(mq.pop_front()); m_el = 1;
      end else if (m_to != 0 && m_el >= m_to) begin
        m_err = 1; m_ecode = mq[0].code; m_etile = mq[0].tile; mq.delete();
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] cd;
    logic [4:0] eph;
    cd = m_code();
    eph = (cd >= 4'd1 && cd <= 4'd5) ? (5'b10000 >> (cd - 4'd1)) : 5'b00000;
    chk("state", state_o, cd);
    chk("phases", {weight_load_state_o, init_fifo_pe_state_o, preheat_state_o,
                   normal_loop_state_o, drain_state_o}, eph);
    chk("phase_start", phase_start_o, (eph != 5'd0) && (cd != m_prev));
    chk("busy", busy_o, cd != 4'd0);
    chk("pass_done", pass_done_o, cd == 4'd7);
    chk("tile_idx", tile_idx_o, m_tile());
    chk("is_bias", is_bias_o, m_bias && m_tile() == 0 && cd != 4'd0);
    chk("error", error_o, m_err);
    chk("err_code", err_code_o, m_err ? m_ecode : 4'd0);
    chk("layer_type", layer_type_o, m_layer);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to_idle(input string nm);
    for (int c = 0; c < 60 && busy_o; c++) tick();
    chk(nm, busy_o, 1'b0);
  endtask

  typedef struct {
    logic start, abrt; logic [3:0] dones; logic [15:0] tn;
    logic [3:0] est; logic edone, eps;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic a, logic [3:0] d, logic [15:0] tn,
                              logic [3:0] st, logic ed, logic ps);
    vec_t v;
    v.start = s; v.abrt = a; v.dones = d; v.tn = tn; v.est = st; v.edone = ed; v.eps = ps;
    return v;
  endfunction

  initial begin
    int wl_cy, bias_cy, bias_bad, max_tile, done_at, ph_cy;
    // dones = {weight_load, preheat, normal_loop, drain}
    tbl.push_back(mk(1,0,4'hF,16'd1,4'd1,0,1)); tbl.push_back(mk(0,0,4'hF,16'd1,4'd2,0,1));
    tbl.push_back(mk(0,0,4'hF,16'd1,4'd3,0,1)); tbl.push_back(mk(0,0,4'hF,16'd1,4'd4,0,1));
    tbl.push_back(mk(0,0,4'hF,16'd1,4'd5,0,1)); tbl.push_back(mk(0,0,4'hF,16'd1,4'd6,0,0));
    tbl.push_back(mk(0,0,4'hF,16'd1,4'd7,1,0)); tbl.push_back(mk(0,0,4'hF,16'd1,4'd0,0,0));
    tbl.push_back(mk(1,0,4'h0,16'd1,4'd1,0,1)); tbl.push_back(mk(1,0,4'h0,16'd1,4'd1,0,0));
    tbl.push_back(mk(0,0,4'h8,16'd1,4'd2,0,1)); tbl.push_back(mk(0,0,4'h0,16'd1,4'd3,0,1));
    tbl.push_back(mk(0,0,4'h2,16'd1,4'd3,0,0)); tbl.push_back(mk(0,0,4'h4,16'd1,4'd4,0,1));
    tbl.push_back(mk(0,0,4'h2,16'd1,4'd5,0,1)); tbl.push_back(mk(1,0,4'h1,16'd1,4'd6,0,0));
    tbl.push_back(mk(0,0,4'h0,16'd1,4'd7,1,0)); tbl.push_back(mk(1,0,4'h0,16'd1,4'd0,0,0));
    tbl.push_back(mk(0,0,4'h0,16'd1,4'd0,0,0)); tbl.push_back(mk(1,1,4'h0,16'd1,4'd1,0,1));
    tbl.push_back(mk(0,1,4'h0,16'd1,4'd0,0,0)); tbl.push_back(mk(1,0,4'h0,16'd0,4'd7,1,0));
    tbl.push_back(mk(0,0,4'h0,16'd0,4'd0,0,0));

    model_reset();
    #12;
    check_all();
    chk("reset_tile_idx", tile_idx_o, 16'd0);
    rst = 1'b0;
    tick();

    layer_type = 2'd2;
    foreach (tbl[i]) begin
      pass_start = tbl[i].start; abort = tbl[i].abrt; tile_num = tbl[i].tn;
      {wl_done, ph_done, nl_done, dr_done} = tbl[i].dones;
      tick();
      chk($sformatf("tbl%0d_state", i), state_o, tbl[i].est);
      chk($sformatf("tbl%0d_done", i), pass_done_o, tbl[i].edone);
      chk($sformatf("tbl%0d_pstart", i), phase_start_o, tbl[i].eps);
    end
    pass_start = 0; abort = 0;

    // Weight reuse with bias, three tiles
    tile_num = 16'd3; weight_reuse = 1; bias_en = 1; layer_type = 2'd1;
    {wl_done, ph_done, nl_done, dr_done} = 4'hF;
    pass_start = 1; tick(); pass_start = 0;
    wl_cy = 0; bias_cy = 0; bias_bad = 0; max_tile = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (weight_load_state_o) wl_cy++;
      if (is_bias_o) bias_cy++;
      if (is_bias_o && tile_idx_o != 16'd0) bias_bad++;
      if (int'(tile_idx_o) > max_tile) max_tile = int'(tile_idx_o);
      if (pass_done_o) begin done_at = c; break; end
      tick();
    end
    chk("reuse_wload_cycles", wl_cy, 1);
    chk("reuse_bias_cycles", bias_cy, 6);
    chk("reuse_bias_bad", bias_bad, 0);
    chk("reuse_max_tile", max_tile, 2);
    chk("reuse_done_cycle", done_at, 17);
    run_to_idle("reuse_idle");
    weight_reuse = 0; bias_en = 0;

    // Watchdog: preheat never completes, then completes on cycle 10
    for (int v = 0; v < 2; v++) begin
      tile_num = 16'd1; timeout_cycles = 20'd10;
      {wl_done, ph_done, nl_done, dr_done} = 4'b1011;
      pass_start = 1; tick(); pass_start = 0;
      ph_cy = 0;
      for (int c = 0; c < 30; c++) begin
        if (state_o == 4'd8 || state_o == 4'd4) break;
        if (state_o == 4'd3) begin ph_cy++; ph_done = (v == 1) && (ph_cy == 10); end
        tick();
      end
      ph_done = 0;
      chk($sformatf("wd%0d_preheat_cycles", v), ph_cy, 10);
      chk($sformatf("wd%0d_state", v), state_o, (v == 0) ? 4'd8 : 4'd4);
      chk($sformatf("wd%0d_error", v), error_o, v == 0);
      chk($sformatf("wd%0d_code", v), err_code_o, (v == 0) ? 4'd3 : 4'd0);
      if (v == 0) begin
        for (int c = 0; c < 3; c++) begin
          ph_done = (c == 1); tick();
          chk("wd_err_hold", state_o, 4'd8);
        end
        ph_done = 0; abort = 1; tick(); abort = 0;
        chk("wd_abort_state", state_o, 4'd0);
        chk("wd_abort_error", error_o, 1'b0);
        chk("wd_abort_code", err_code_o, 4'd0);
      end else begin
        run_to_idle("wd_done_idle");
      end
    end
    timeout_cycles = 20'd0;

    // Abort mid-NORMAL on tile 1 of 4
    tile_num = 16'd4; {wl_done, ph_done, dr_done} = 3'b111; nl_done = 1;
    pass_start = 1; tick(); pass_start = 0;
    for (int c = 0; c < 60; c++) begin
      if (state_o == 4'd4 && tile_idx_o == 16'd1) break;
      nl_done = (tile_idx_o == 16'd0);
      tick();
    end
    chk("abort_reached_tile1_normal", {state_o, tile_idx_o}, {4'd4, 16'd1});
    nl_done = 0; abort = 1; tick(); abort = 0;
    chk("abort_phases", {weight_load_state_o, init_fifo_pe_state_o, preheat_state_o,
                         normal_loop_state_o, drain_state_o}, 5'd0);
    chk("abort_tile", tile_idx_o, 16'd0);
    chk("abort_no_done", pass_done_o, 1'b0);
    tile_num = 16'd1; {wl_done, ph_done, nl_done, dr_done} = 4'hF;
    pass_start = 1; tick(); pass_start = 0;
    chk("abort_restart", state_o, 4'd1);
    run_to_idle("abort_restart_idle");

    // Asynchronous reset mid-DRAIN
    tile_num = 16'd2; {wl_done, ph_done, nl_done, dr_done} = 4'b1110; layer_type = 2'd3;
    pass_start = 1; tick(); pass_start = 0;
    for (int c = 0; c < 30 && state_o != 4'd5; c++) tick();
    chk("rst_reached_drain", state_o, 4'd5);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    #2 rst = 0;
    {wl_done, ph_done, nl_done, dr_done} = 4'h0;
    tick();

    // Randomized stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      pass_start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 24) == 0);
      tile_num = 16'($urandom_range(0, 3));
      weight_reuse = $urandom_range(0, 1) == 1;
      bias_en = $urandom_range(0, 1) == 1;
      layer_type = 2'($urandom_range(0, 3));
      timeout_cycles = 20'($urandom_range(0, 6));
      wl_done = ($urandom_range(0, 2) == 0);
      ph_done = ($urandom_range(0, 2) == 0);
      nl_done = ($urandom_range(0, 2) == 0);
      dr_done = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
